// File: rtl/instr_queue.sv
// -----------------------------------------------------------------------------
// instr_queue
//
// Instruction buffer sitting between fetch and decode. Holds up to DEPTH
// instructions, each tagged with its PC, in a circular FIFO with valid/ready
// handshakes on both sides. The standard RISC-V register and opcode fields are
// decoded from the head entry. A flush discards everything buffered (redirect).
//
// Optional feature macro: INSTR_QUEUE_BYPASS_EN
//   defined   -> when the queue is empty, an incoming instruction is presented
//                on the output in the same cycle (0-cycle latency); if decode
//                takes it in that cycle it is never stored.
//   undefined -> registered path only, 1-cycle latency from push to out_valid.
//
// Parameters:
//   WIDTH  instruction width (>= 32); decoded fields come from bits [31:0]
//   PC_W   PC tag width
//   DEPTH  number of entries (power of two, >= 2)
//
// Ports:
//   clk        clock, all state updates on rising edge
//   reset_n    synchronous active-low reset
//   flush      discard all entries on the next edge
//   in_valid   fetch presents in_instr/in_pc
//   in_ready   queue can accept (count != DEPTH), registered state only
//   in_instr   instruction word
//   in_pc      PC of in_instr
//   out_valid  head entry valid
//   out_ready  decode consumes the head entry
//   out_instr  head instruction (0 when out_valid = 0)
//   out_pc     head PC (0 when out_valid = 0)
//   rs2/rs1/rd/funct3/opcode  slices of out_instr
//   count      number of stored entries
// -----------------------------------------------------------------------------
module instr_queue #(
  parameter int WIDTH = 32,
  parameter int PC_W  = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_instr,
  input  logic [PC_W-1:0]          in_pc,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_instr,
  output logic [PC_W-1:0]          out_pc,
  output logic [4:0]               rs2,
  output logic [4:0]               rs1,
  output logic [4:0]               rd,
  output logic [2:0]               funct3,
  output logic [6:0]               opcode,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  // Entry storage. Read is asynchronous because the head entry must be
  // visible in the cycle right after the push edge.
  logic [WIDTH-1:0] instr_mem [DEPTH];
  logic [PC_W-1:0]  pc_mem    [DEPTH];

  logic [AW-1:0] rd_ptr_reg, rd_ptr_next;
  logic [AW-1:0] wr_ptr_reg, wr_ptr_next;
  logic [CW-1:0] count_reg,  count_next;

  logic             empty;
  logic             bypass_active;
  logic             push;
  logic             pop;
  logic             store;    // push that actually lands in storage
  logic             pop_mem;  // pop that actually removes a stored entry
  logic             mem_we;
  logic [WIDTH-1:0] head_instr;
  logic [PC_W-1:0]  head_pc;

  // ---------------------------------------------------------------------------
  // Status
  // ---------------------------------------------------------------------------
  assign empty    = (count_reg == '0);
  assign in_ready = (count_reg != CW'(DEPTH));

`ifdef INSTR_QUEUE_BYPASS_EN
  // An empty queue forwards the incoming instruction straight to decode.
  assign bypass_active = empty && in_valid && !flush;
  assign head_instr    = bypass_active ? in_instr : instr_mem[rd_ptr_reg];
  assign head_pc       = bypass_active ? in_pc    : pc_mem[rd_ptr_reg];
`else
  assign bypass_active = 1'b0;
  assign head_instr    = instr_mem[rd_ptr_reg];
  assign head_pc       = pc_mem[rd_ptr_reg];
`endif

  assign out_valid = !empty || bypass_active;

  assign push = in_valid && in_ready;
  assign pop  = out_valid && out_ready;

  // A bypassed instruction that decode accepts in the same cycle is consumed
  // on the fly: it is neither written nor popped from storage. A bypassed
  // instruction that is not accepted is stored like any other push (the
  // queue is empty, so nothing is popped from storage in that case).
  assign store   = push && !(bypass_active && out_ready);
  assign pop_mem = pop && !bypass_active;

  // Flush and reset both win over the handshake; don't bother writing then.
  assign mem_we = store && reset_n && !flush;

  // ---------------------------------------------------------------------------
  // Next-state
  // ---------------------------------------------------------------------------
  always_comb begin
    rd_ptr_next = rd_ptr_reg;
    wr_ptr_next = wr_ptr_reg;
    count_next  = count_reg;
    if (flush) begin
      rd_ptr_next = '0;
      wr_ptr_next = '0;
      count_next  = '0;
    end else begin
      if (store) begin
        wr_ptr_next = wr_ptr_reg + AW'(1);
      end
      if (pop_mem) begin
        rd_ptr_next = rd_ptr_reg + AW'(1);
      end
      count_next = count_reg + CW'(store) - CW'(pop_mem);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      rd_ptr_reg <= rd_ptr_next;
      wr_ptr_reg <= wr_ptr_next;
      count_reg  <= count_next;
    end
  end

  // Storage has no reset: stale contents are masked by count/out_valid.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      instr_mem[wr_ptr_reg] <= in_instr;
      pc_mem[wr_ptr_reg]    <= in_pc;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign out_instr = out_valid ? head_instr : '0;
  assign out_pc    = out_valid ? head_pc    : '0;
  assign count     = count_reg;

  assign rs2    = out_instr[24:20];
  assign rs1    = out_instr[19:15];
  assign rd     = out_instr[11:7];
  assign funct3 = out_instr[14:12];
  assign opcode = out_instr[6:0];

endmodule

// File: tb/tb_instr_queue.sv
// -----------------------------------------------------------------------------
// tb_instr_queue
//
// Drives instr_queue cycle by cycle (directed scenarios followed by random
// traffic) and compares every output against a queue-based reference model.
// Inputs change 1 ns after the rising edge; outputs are sampled mid-cycle.
// -----------------------------------------------------------------------------
module tb_instr_queue;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [4:0]  rs2, rs1, rd;
  logic [2:0]  funct3;
  logic [6:0]  opcode;
  logic [2:0]  count;

  always #5 clk = ~clk;

  instr_queue #(.WIDTH(32), .PC_W(32), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_instr  (in_instr),
    .in_pc     (in_pc),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_instr (out_instr),
    .out_pc    (out_pc),
    .rs2       (rs2),
    .rs1       (rs1),
    .rd        (rd),
    .funct3    (funct3),
    .opcode    (opcode),
    .count     (count)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  ent_t mq[$];        // reference contents, head at index 0
  bit   known = 0;    // model valid once the first reset edge has passed
  int   checks = 0;
  int   passes = 0;
  int   cyc = 0;

  // Outputs captured at the sample point of the most recent cycle
  logic        s_out_valid, s_in_ready;
  logic [2:0]  s_count;
  logic [31:0] s_out_instr, s_out_pc;
  logic [4:0]  s_rs1, s_rs2, s_rd;
  logic [2:0]  s_funct3;
  logic [6:0]  s_opcode;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp)
      $display("FAIL %s cyc=%0d: got 0x%0h expected 0x%0h", tag, cyc, obs, exp);
    else
      passes++;
  endtask

  task automatic run_cycle(input bit rn, input bit fl, input bit iv,
                           input logic [31:0] ins, input logic [31:0] pc, input bit ordy);
    int          sz;
    bit          byp, exp_ov, acc, pp;
    logic [31:0] h_i, h_pc;
    reset_n = rn; flush = fl; in_valid = iv; in_instr = ins; in_pc = pc; out_ready = ordy;
    #4;
    s_out_valid = out_valid; s_in_ready = in_ready; s_count = count;
    s_out_instr = out_instr; s_out_pc = out_pc;
    s_rs1 = rs1; s_rs2 = rs2; s_rd = rd; s_funct3 = funct3; s_opcode = opcode;

    sz  = mq.size();
    byp = 0;
`ifdef INSTR_QUEUE_BYPASS_EN
    byp = (sz == 0) && iv && !fl;
`endif
    exp_ov = (sz != 0) || byp;
    h_i = 0; h_pc = 0;
    if (byp) begin
      h_i = ins; h_pc = pc;
    end else if (sz != 0) begin
      h_i = mq[0].instr; h_pc = mq[0].pc;
    end

    if (known) begin
      check_val("out_valid", 64'(s_out_valid), 64'(exp_ov));
      check_val("in_ready",  64'(s_in_ready),  64'(sz < DEPTH));
      check_val("count",     64'(s_count),     64'(sz));
      check_val("out_instr", 64'(s_out_instr), 64'(h_i));
      check_val("out_pc",    64'(s_out_pc),    64'(h_pc));
      check_val("rs1",       64'(s_rs1),       64'((h_i >> 15) % 32));
      check_val("rs2",       64'(s_rs2),       64'((h_i >> 20) % 32));
      check_val("rd",        64'(s_rd),        64'((h_i >> 7) % 32));
      check_val("funct3",    64'(s_funct3),    64'((h_i >> 12) % 8));
      check_val("opcode",    64'(s_opcode),    64'(h_i % 128));
    end

    @(posedge clk);
    acc = 0; pp = 0;
    if (!rn) begin
      mq.delete();
      known = 1;
    end else if (fl) begin
      mq.delete();
    end else begin
      acc = iv && (sz < DEPTH);
      pp  = exp_ov && ordy;
      if (!(byp && ordy)) begin
        if (pp) void'(mq.pop_front());
        if (acc) mq.push_back('{pc: pc, instr: ins});
      end
    end
    if (acc || pp)
      $display("cyc %0d push=%0b pc=%08h pop=%0b pc=%08h instr=%08h size=%0d",
               cyc, acc, pc, pp, h_pc, h_i, mq.size());
    cyc++;
    #1;
  endtask

  task automatic idle(input bit ordy);
    run_cycle(1, 0, 0, 32'h0, 32'h0, ordy);
  endtask

  initial begin
    reset_n = 0; flush = 0; in_valid = 0; in_instr = 0; in_pc = 0; out_ready = 0;

    // Reset for two cycles, then idle
    run_cycle(0, 0, 0, 0, 0, 0);
    run_cycle(0, 0, 0, 0, 0, 0);
    idle(0);
    check_val("rst_in_ready",  64'(s_in_ready),  64'd1);
    check_val("rst_out_valid", 64'(s_out_valid), 64'd0);
    check_val("rst_count",     64'(s_count),     64'd0);
    check_val("rst_out_instr", 64'(s_out_instr), 64'd0);

    // Single push, decode fields on the next cycle
    run_cycle(1, 0, 1, 32'h00C58533, 32'h100, 0);
    idle(0);
    check_val("p1_out_valid", 64'(s_out_valid), 64'd1);
    check_val("p1_out_pc",    64'(s_out_pc),    64'h100);
    check_val("p1_rs1",       64'(s_rs1),       64'd11);
    check_val("p1_rs2",       64'(s_rs2),       64'd12);
    check_val("p1_rd",        64'(s_rd),        64'd10);
    check_val("p1_funct3",    64'(s_funct3),    64'd0);
    check_val("p1_opcode",    64'(s_opcode),    64'h33);
    check_val("p1_count",     64'(s_count),     64'd1);

    // Fill to DEPTH, fifth push refused, then pop with a push attempt
    for (int i = 0; i < 3; i++) run_cycle(1, 0, 1, $urandom, 32'h200 + 32'(4 * i), 0);
    run_cycle(1, 0, 1, 32'hDEAD_BEEF, 32'h300, 0);
    check_val("full_in_ready", 64'(s_in_ready), 64'd0);
    check_val("full_count",    64'(s_count),    64'd4);
    run_cycle(1, 0, 1, 32'hDEAD_BEEF, 32'h304, 1);
    check_val("full_no_push", 64'(s_count), 64'd4);
    idle(0);
    check_val("full_pop_only", 64'(s_count), 64'd3);

    // Stream eight instructions across pointer wrap
    run_cycle(1, 1, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) begin
      run_cycle(1, 0, 1, $urandom, 32'h1000 + 32'(4 * i), 1);
      check_val("stream_cnt_le1", 64'(s_count <= 3'd1), 64'd1);
    end
    idle(1);
    idle(1);

    // Flush with three held entries and a concurrent push
    for (int i = 0; i < 3; i++) run_cycle(1, 0, 1, $urandom, 32'h2000 + 32'(4 * i), 0);
    run_cycle(1, 1, 1, 32'h1234_5678, 32'h2100, 1);
    idle(0);
    check_val("flush_count",     64'(s_count),     64'd0);
    check_val("flush_out_valid", 64'(s_out_valid), 64'd0);

    // Empty queue push with out_ready high
    run_cycle(1, 0, 1, 32'h0000_0013, 32'h3000, 1);
`ifdef INSTR_QUEUE_BYPASS_EN
    check_val("byp_out_valid", 64'(s_out_valid), 64'd1);
    check_val("byp_opcode",    64'(s_opcode),    64'h13);
    idle(0);
    check_val("byp_count", 64'(s_count), 64'd0);
`else
    check_val("nobyp_out_valid0", 64'(s_out_valid), 64'd0);
    idle(0);
    check_val("nobyp_out_valid1", 64'(s_out_valid), 64'd1);
    check_val("nobyp_opcode",     64'(s_opcode),    64'h13);
`endif

    // Random traffic, with varying push/pop pressure per block
    for (int blk = 0; blk < 4; blk++) begin
      int p_in, p_out;
      p_in  = (blk % 2 == 0) ? 80 : 40;
      p_out = (blk < 2) ? 30 : 80;
      for (int i = 0; i < 100; i++) begin
        bit rn, fl, iv, ordy;
        rn   = ($urandom_range(0, 99) >= 1);
        fl   = ($urandom_range(0, 99) < 4);
        iv   = ($urandom_range(0, 99) < p_in);
        ordy = ($urandom_range(0, 99) < p_out);
        run_cycle(rn, fl, iv, $urandom, $urandom, ordy);
      end
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
